// File: rtl/fft_pkg.sv
// Shared FSM encoding and default sizing for the FFT ping-pong input buffer.
package fft_pkg;

    localparam int NFFT_DEF   = 8;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2
    } fft_state_e;

endpackage

// File: rtl/fft_bank_ram.sv
// Two-bank sample store: one word write port, one registered read port returning {imag, real}.
module fft_bank_ram
    import fft_pkg::*;
#(
    parameter int NFFT   = NFFT_DEF,
    parameter int DATA_W = DATA_W_DEF
)(
    input  logic                      clk_i,
    input  logic                      we_i,
    input  logic                      wbank_i,
    input  logic [$clog2(2*NFFT)-1:0] waddr_i,
    input  logic [DATA_W-1:0]         wdata_i,
    input  logic                      re_i,
    input  logic                      rbank_i,
    input  logic [$clog2(NFFT)-1:0]   raddr_i,
    output logic [2*DATA_W-1:0]       rdata_o
);

    localparam int AW = $clog2(2*NFFT);
    localparam int KW = $clog2(NFFT);

    // Real and imaginary halves live in separate arrays so a whole sample reads in one cycle.
    logic [DATA_W-1:0]   mem_re_q [2*NFFT];
    logic [DATA_W-1:0]   mem_im_q [2*NFFT];
    logic [2*DATA_W-1:0] rdata_q;
    logic [KW:0]         widx;
    logic [KW:0]         ridx;

    assign widx = {wbank_i, waddr_i[AW-1:1]};
    assign ridx = {rbank_i, raddr_i};

    always_ff @(posedge clk_i) begin
        if (we_i && !waddr_i[0]) begin
            mem_re_q[widx] <= wdata_i;
        end
        if (we_i && waddr_i[0]) begin
            mem_im_q[widx] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= {mem_im_q[ridx], mem_re_q[ridx]};
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_pingpong_input.sv
// Ping-pong frame buffer: a host fills one bank while the other streams out as AXIS samples.
//   state     | meaning
//   ST_IDLE   | nothing committed, waiting for pending > 0
//   ST_LOAD   | first sample read issued, RAM latency cycle
//   ST_STREAM | tvalid high, one sample per accepted beat
module fft_pingpong_input
    import fft_pkg::*;
#(
    parameter int NFFT   = NFFT_DEF,
    parameter int DATA_W = DATA_W_DEF
)(
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [$clog2(2*NFFT)-1:0] w_addr_i,
    input  logic [31:0]               w_data_i,
    input  logic                      w_en_i,
    input  logic                      trig_i,
    input  logic                      clr_ovf_i,
    input  logic                      tready_i,
    output logic                      tvalid_o,
    output logic                      tlast_o,
    output logic [2*DATA_W-1:0]       tdata_o,
    output logic                      streaming_o,
    output logic [1:0]                pending_o,
    output logic                      overflow_o,
    output logic                      done_o
);

    localparam int            KW     = $clog2(NFFT);
    localparam logic [KW-1:0] K_LAST = KW'(NFFT - 1);

    fft_state_e          state_q, state_d;
    logic [1:0]          pending_q, pending_d;
    logic                wr_bank_q, wr_bank_d;
    logic                rd_bank_q, rd_bank_d;
    logic [KW-1:0]       k_q, k_d;
    logic                overflow_q, overflow_d;
    logic                done_q, done_d;
    logic                rd_en;
    logic [KW-1:0]       rd_addr;
    logic [2*DATA_W-1:0] rd_data;
    logic                full, hs, last_hs, trig_ok, wr_ok;
    logic                unused_wdata;

    assign unused_wdata = ^w_data_i;

    assign full     = (pending_q == 2'd2);
    assign tvalid_o = (state_q == ST_STREAM);
    assign tlast_o  = tvalid_o && (k_q == K_LAST);
    assign hs       = tvalid_o && tready_i;
    assign last_hs  = hs && tlast_o;
    // A frame retiring in the same cycle frees a slot, so that trig is always accepted.
    assign trig_ok  = trig_i && (!full || last_hs);
    assign wr_ok    = w_en_i && !full;

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        k_d        = k_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = k_q;

        if (trig_ok) begin
            wr_bank_d = ~wr_bank_q;
        end
        if (trig_ok && !last_hs) begin
            pending_d = pending_q + 2'd1;
        end else if (!trig_ok && last_hs) begin
            pending_d = pending_q - 2'd1;
        end

        if (clr_ovf_i) begin
            overflow_d = 1'b0;
        end
        if ((trig_i && !trig_ok) || (w_en_i && full)) begin
            overflow_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (pending_q != 2'd0) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                rd_en   = 1'b1;
                rd_addr = '0;
                k_d     = '0;
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (hs) begin
                    if (tlast_o) begin
                        rd_bank_d = ~rd_bank_q;
                        done_d    = 1'b1;
                        state_d   = (pending_d != 2'd0) ? ST_LOAD : ST_IDLE;
                    end else begin
                        rd_en   = 1'b1;
                        rd_addr = k_q + KW'(1);
                        k_d     = k_q + KW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            pending_q  <= 2'd0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            k_q        <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            k_q        <= k_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    fft_bank_ram #(
        .NFFT   (NFFT),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (wr_ok),
        .wbank_i (wr_bank_q),
        .waddr_i (w_addr_i),
        .wdata_i (w_data_i[DATA_W-1:0]),
        .re_i    (rd_en),
        .rbank_i (rd_bank_q),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    // RAM output is not reset, so gate it to keep tdata at zero outside a frame.
    assign tdata_o     = tvalid_o ? rd_data : '0;
    assign streaming_o = (state_q != ST_IDLE);
    assign pending_o   = pending_q;
    assign overflow_o  = overflow_q;
    assign done_o      = done_q;

endmodule
